tt_um_serial_subtractor: RTL and testbench

- Bit-serial 8-bit unsigned subtractor, built as the sequential companion to the team's combinational half-adder tile. It computes A − B, the inverse operation.
- It is a TinyTapeout user top, on the standard pin set.
- Operands enter through ui_in under load strobes on uio_in. A start strobe triggers WIDTH cycles of LSB-first shifting through a full-subtractor cell.
- Result, borrow, zero and busy/done status are presented on output pins.

---
 rtl/tt_serial_pkg.sv | 21 ++
 rtl/full_subtractor_cell.sv | 13 +
 rtl/tt_um_serial_subtractor.sv | 166 ++++++++++++++++
 tb/tb_tt_um_serial_subtractor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tt_serial_pkg.sv
// Shared definitions for the serial arithmetic tiles: FSM states and TinyTapeout
// uio pin assignments.
package tt_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int UIO_LOAD_A = 0;
   localparam int UIO_LOAD_B = 1;
   localparam int UIO_START  = 2;
   localparam int UIO_BUSY   = 4;
   localparam int UIO_DONE   = 5;
   localparam int UIO_BORROW = 6;
   localparam int UIO_ZERO   = 7;

   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial unsigned subtractor (A - B mod 2^WIDTH), LSB first, one bit per enabled
// clock, with synchronized load/start strobes on uio_in.
module tt_um_serial_subtractor
   import tt_serial_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam int NSTROBE = 3;
   localparam int CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [NSTROBE-1:0] ev;
   logic               live_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live_q <= 1'b0;
      else        live_q <= 1'b1;
   end

   // A strobe only arms once its pin has been seen low after reset, so a pin
   // already high at reset release never produces an event.
   generate
      for (genvar gi = 0; gi < NSTROBE; gi++) begin : g_strobe
         logic [SYNC_STAGES-1:0] sync_q, sync_d;
         logic                   prev_q, prev_d;
         logic                   arm_q, arm_d;

         always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], uio_in[gi]};
            prev_d = sync_q[SYNC_STAGES-1];
            arm_d  = arm_q | (live_q & ~sync_q[0]);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
               prev_q <= 1'b0;
               arm_q  <= 1'b0;
            end else begin
               sync_q <= sync_d;
               prev_q <= prev_d;
               arm_q  <= arm_d;
            end
         end

         assign ev[gi] = sync_q[SYNC_STAGES-1] & ~prev_q & arm_q;
      end
   endgenerate

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bw_q, bw_d, borrow_q, borrow_d, zero_q, zero_d;
   logic             d_bit, bout_bit;
   logic [WIDTH-1:0] sr_shift;

   full_subtractor_cell u_cell (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .bin  (bw_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign sr_shift = {d_bit, sr_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      bw_d     = bw_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      if (ena) begin
         unique case (state_q)
            IDLE, DONE: begin
               if (ev[UIO_START]) begin
                  sa_d    = a_q;
                  sb_d    = b_q;
                  bw_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end else if (ev[UIO_LOAD_A] || ev[UIO_LOAD_B]) begin
                  if (ev[UIO_LOAD_A]) a_d = ui_in[WIDTH-1:0];
                  if (ev[UIO_LOAD_B]) b_d = ui_in[WIDTH-1:0];
                  state_d = IDLE;
               end
            end
            SHIFT: begin
               sa_d  = sa_q >> 1;
               sb_d  = sb_q >> 1;
               sr_d  = sr_shift;
               bw_d  = bout_bit;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  res_d    = sr_shift;
                  borrow_d = bout_bit;
                  zero_d   = (sr_shift == '0);
                  state_d  = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         sr_q     <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         bw_q     <= 1'b0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         bw_q     <= bw_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      uio_out             = '0;
      uio_out[UIO_BUSY]   = (state_q == SHIFT);
      uio_out[UIO_DONE]   = (state_q == DONE);
      uio_out[UIO_BORROW] = borrow_q;
      uio_out[UIO_ZERO]   = zero_q;
   end

   assign uo_out = 8'(res_q);
   assign uio_oe = UIO_OE_MASK;

   logic unused_ok;
   assign unused_ok = &{1'b0, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed and randomized bench for the serial subtractor; expected results come
// from plain modular arithmetic on the operands the bench has loaded.
module tb_tt_um_serial_subtractor;

   localparam int WIDTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int checks = 0;
   int failures = 0;
   int unsigned ma = 0;
   int unsigned mb = 0;

   tt_um_serial_subtractor #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int idx, input logic [7:0] v);
      ui_in = v;
      uio_in[idx] = 1'b1;
      repeat (4) @(negedge clk);
      uio_in[idx] = 1'b0;
      repeat (3) @(negedge clk);
      if (idx == 0) ma = v;
      else          mb = v;
      $display("load %s = 0x%02h", (idx == 0) ? "A" : "B", v);
   endtask

   task automatic run_op(input string tag, input int stall_at, input int stall_len, input bit inject);
      logic [7:0] exp_r;
      logic       exp_b;
      int         n;
      int         waitc;
      exp_r = 8'((ma + 256 - mb) % 256);
      exp_b = (ma < mb);
      uio_in[2] = 1'b1;
      waitc = 0;
      while (!uio_out[4] && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_busy_rise"}, uio_out[4], 1);
      uio_in[2] = 1'b0;
      n = 0;
      while (uio_out[4] && n < 60) begin
         n++;
         if (inject && n == 2) begin
            ui_in = 8'hFF;
            uio_in[0] = 1'b1;
            uio_in[2] = 1'b1;
         end
         if (stall_len > 0 && n == stall_at) ena = 1'b0;
         if (stall_len > 0 && n == stall_at + stall_len) ena = 1'b1;
         @(negedge clk);
      end
      ena = 1'b1;
      check({tag, "_busy_cycles"}, n, WIDTH + stall_len);
      check({tag, "_done"}, uio_out[5], 1);
      check({tag, "_result"}, uo_out, exp_r);
      check({tag, "_borrow"}, uio_out[6], exp_b);
      check({tag, "_zero"}, uio_out[7], (exp_r == 8'h00));
      $display("op %s: A=0x%02h B=0x%02h -> uo_out=0x%02h borrow=%0b zero=%0b busy_cycles=%0d",
               tag, ma[7:0], mb[7:0], uo_out, uio_out[6], uio_out[7], n);
      if (inject) begin
         uio_in[0] = 1'b0;
         uio_in[2] = 1'b0;
         repeat (3) @(negedge clk);
         check({tag, "_done_after_drop"}, uio_out[5], 1);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_uo_out", uo_out, 8'h00);
      check("rst_uio_out", uio_out, 8'h00);
      check("rst_uio_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      load(0, 8'd100);
      load(1, 8'd37);
      run_op("basic", 0, 0, 1'b0);

      load(0, 8'd37);
      load(1, 8'd100);
      run_op("borrow", 0, 0, 1'b0);
      load(0, 8'd0);
      load(1, 8'd1);
      run_op("zero_minus_one", 0, 0, 1'b0);

      load(0, 8'h55);
      load(1, 8'h55);
      run_op("equal", 0, 0, 1'b0);
      load(0, 8'h12);
      check("load_in_done_clears_done", uio_out[5], 0);
      check("load_in_done_keeps_uo", uo_out, 8'h00);
      check("load_in_done_keeps_zero", uio_out[7], 1);
      check("load_in_done_not_busy", uio_out[4], 0);

      load(0, 8'd200);
      load(1, 8'd55);
      run_op("inject", 0, 0, 1'b1);
      run_op("rerun_after_inject", 0, 0, 1'b0);

      run_op("stall", 3, 5, 1'b0);

      for (int i = 0; i < 6; i++) begin
         load(0, 8'($urandom_range(0, 255)));
         load(1, 8'($urandom_range(0, 255)));
         run_op("random", 0, 0, 1'b0);
      end

      load(0, 8'd9);
      load(1, 8'd3);
      uio_in[2] = 1'b1;
      for (int w = 0; w < 10 && !uio_out[4]; w++) @(negedge clk);
      check("reset_pre_busy", uio_out[4], 1);
      uio_in[2] = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midshift_rst_uo_out", uo_out, 8'h00);
      check("midshift_rst_uio_out", uio_out, 8'h00);
      check("midshift_rst_uio_oe", uio_oe, 8'hF0);
      ma = 0;
      mb = 0;
      uio_in[2] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("start_held_through_release_busy", uio_out[4], 0);
      check("start_held_through_release_done", uio_out[5], 0);
      $display("reset release with start held: busy=%0b done=%0b", uio_out[4], uio_out[5]);
      uio_in[2] = 1'b0;
      repeat (3) @(negedge clk);
      run_op("post_reset", 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
